// File: rtl/plot_sequencer.sv
// Round-robin pixel sequencer for the vga_adapter plot port: full-screen clear
// sweep on round start, then N player heads plus the timer-bar pixel, one per clock.

module plot_sequencer_lane #(
  parameter int X_W      = 8,
  parameter int Y_W      = 7,
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120
) (
  input  logic               en,
  input  logic [X_W+Y_W-1:0] p,
  output logic               valid,
  output logic [X_W-1:0]     px,
  output logic [Y_W-1:0]     py
);
  assign px = p[X_W+Y_W-1 -: X_W];
  assign py = p[Y_W-1:0];

  // Extra bit on the compare so a screen of exactly 2^X_W / 2^Y_W still works.
  assign valid = en
              && ({1'b0, px} < (X_W+1)'(SCREEN_W))
              && ({1'b0, py} < (Y_W+1)'(SCREEN_H));
endmodule

module plot_sequencer #(
  parameter int             NUM_PLAYERS  = 4,
  parameter int             X_W          = 8,
  parameter int             Y_W          = 7,
  parameter int             SCREEN_W     = 160,
  parameter int             SCREEN_H     = 120,
  parameter int             TIMER_Y      = 119,
  parameter int             TIMER_LEN    = 158,
  parameter logic [2:0]     BG_COLOUR    = 3'b000,
  parameter logic [2:0]     TIMER_COLOUR = 3'b111
) (
  input  logic                             CLOCK_50,
  input  logic                             reset,
  input  logic                             start,
  input  logic                             tick,
  input  logic [NUM_PLAYERS-1:0]           player_en,
  input  logic [NUM_PLAYERS*(X_W+Y_W)-1:0] pos,
  input  logic [NUM_PLAYERS*3-1:0]         colours,
  output logic [X_W-1:0]                   x,
  output logic [Y_W-1:0]                   y,
  output logic [2:0]                       colour,
  output logic                             plot,
  output logic                             running,
  output logic                             clearing,
  output logic [X_W-1:0]                   timer_x,
  output logic                             done
);
  localparam int SW = $clog2(NUM_PLAYERS + 1);
  localparam logic [X_W-1:0] CX_LAST = X_W'(SCREEN_W - 1);
  localparam logic [Y_W-1:0] CY_LAST = Y_W'(SCREEN_H - 1);
  localparam logic [X_W-1:0] T_LAST  = X_W'(TIMER_LEN);
  localparam logic [SW-1:0]  S_LAST  = SW'(NUM_PLAYERS);

  if (NUM_PLAYERS < 1 || NUM_PLAYERS > 8) begin : g_bad_n
    $error("plot_sequencer: NUM_PLAYERS must be 1..8");
  end
  if (SCREEN_W > (1 << X_W)) begin : g_bad_w
    $error("plot_sequencer: SCREEN_W does not fit in X_W bits");
  end
  if (SCREEN_H > (1 << Y_W)) begin : g_bad_h
    $error("plot_sequencer: SCREEN_H does not fit in Y_W bits");
  end

  typedef enum logic [1:0] {IDLE, CLEAR, DRAW} state_t;

  state_t         state;
  logic [X_W-1:0] cx;
  logic [Y_W-1:0] cy;
  logic [SW-1:0]  slot;

  // Candidate pixel per slot; the extra top entry is the timer bar, so the
  // slot counter indexes the table directly with no out-of-range case.
  logic [NUM_PLAYERS:0]          sel_vld;
  logic [NUM_PLAYERS:0][X_W-1:0] sel_x;
  logic [NUM_PLAYERS:0][Y_W-1:0] sel_y;
  logic [NUM_PLAYERS:0][2:0]     sel_c;

  for (genvar k = 0; k < NUM_PLAYERS; k++) begin : g_lane
    plot_sequencer_lane #(
      .X_W      (X_W),
      .Y_W      (Y_W),
      .SCREEN_W (SCREEN_W),
      .SCREEN_H (SCREEN_H)
    ) u_lane (
      .en    (player_en[k]),
      .p     (pos[k*(X_W+Y_W) +: X_W+Y_W]),
      .valid (sel_vld[k]),
      .px    (sel_x[k]),
      .py    (sel_y[k])
    );
    assign sel_c[k] = colours[k*3 +: 3];
  end

  assign sel_vld[NUM_PLAYERS] = 1'b1;
  assign sel_x[NUM_PLAYERS]   = timer_x;
  assign sel_y[NUM_PLAYERS]   = Y_W'(TIMER_Y);
  assign sel_c[NUM_PLAYERS]   = TIMER_COLOUR;

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state    <= IDLE;
      cx       <= '0;
      cy       <= '0;
      slot     <= '0;
      x        <= '0;
      y        <= '0;
      colour   <= '0;
      plot     <= 1'b0;
      running  <= 1'b0;
      clearing <= 1'b0;
      timer_x  <= '0;
      done     <= 1'b0;
    end else begin
      plot <= 1'b0;
      done <= 1'b0;
      if (start) begin
        // Start from any state (re)begins the sweep; a coincident tick is dropped.
        state    <= CLEAR;
        cx       <= '0;
        cy       <= '0;
        slot     <= '0;
        running  <= 1'b0;
        clearing <= 1'b1;
      end else begin
        unique case (state)
          IDLE: ;
          CLEAR: begin
            plot   <= 1'b1;
            x      <= cx;
            y      <= cy;
            colour <= BG_COLOUR;
            if (cx == CX_LAST) begin
              cx <= '0;
              if (cy == CY_LAST) begin
                state    <= DRAW;
                slot     <= '0;
                running  <= 1'b1;
                clearing <= 1'b0;
                timer_x  <= '0;
              end else begin
                cy <= cy + 1'b1;
              end
            end else begin
              cx <= cx + 1'b1;
            end
          end
          DRAW: begin
            if (tick && timer_x >= T_LAST) begin
              // Round over: timer_x saturates and the slot pixel is suppressed.
              state   <= IDLE;
              running <= 1'b0;
              done    <= 1'b1;
            end else begin
              if (tick) timer_x <= timer_x + 1'b1;
              if (sel_vld[slot]) begin
                plot   <= 1'b1;
                x      <= sel_x[slot];
                y      <= sel_y[slot];
                colour <= sel_c[slot];
              end
              slot <= (slot == S_LAST) ? '0 : slot + 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_plot_sequencer.sv
// Scoreboard bench for plot_sequencer: a default-size instance plus a small-screen,
// short-timer instance for round expiry and start/tick collision.
module tb_plot_sequencer;
  localparam int N  = 4;
  localparam int XW = 8;
  localparam int YW = 7;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 reset, start, tick, start_t, tick_t;
  logic [N-1:0]         player_en;
  logic [N*(XW+YW)-1:0] pos;
  logic [N*3-1:0]       colours;

  logic [XW-1:0] x, timer_x, x_t, timer_x_t;
  logic [YW-1:0] y, y_t;
  logic [2:0]    colour, colour_t;
  logic          plot, running, clearing, done;
  logic          plot_t, running_t, clearing_t, done_t;

  plot_sequencer dut (
    .CLOCK_50(clk), .reset(reset), .start(start), .tick(tick),
    .player_en(player_en), .pos(pos), .colours(colours),
    .x(x), .y(y), .colour(colour), .plot(plot), .running(running),
    .clearing(clearing), .timer_x(timer_x), .done(done)
  );

  plot_sequencer #(.SCREEN_W(8), .SCREEN_H(4), .TIMER_Y(3), .TIMER_LEN(3)) dut_t (
    .CLOCK_50(clk), .reset(reset), .start(start_t), .tick(tick_t),
    .player_en(player_en), .pos(pos), .colours(colours),
    .x(x_t), .y(y_t), .colour(colour_t), .plot(plot_t), .running(running_t),
    .clearing(clearing_t), .timer_x(timer_x_t), .done(done_t)
  );

  typedef struct packed {logic p; logic [XW-1:0] x; logic [YW-1:0] y; logic [2:0] c;} pix_t;

  pix_t exp_q[$];
  pix_t e, o;
  int   total = 0;
  int   bad   = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_player(input int k, input int px, input int py, input logic [2:0] c);
    pos[k*(XW+YW) +: XW+YW] = {XW'(px), YW'(py)};
    colours[k*3 +: 3]       = c;
  endtask

  task automatic push(input logic p, input int px, input int py, input logic [2:0] c);
    exp_q.push_back({p, XW'(px), YW'(py), c});
  endtask

  // Pop and compare one expected pixel per cycle on the default instance.
  task automatic drain_every_cycle(input string name);
    while (exp_q.size() > 0) begin
      step();
      e = exp_q.pop_front();
      o = {plot, x, y, colour};
      total++;
      if (o !== e) begin
        bad++;
        $display("FAIL %s: got %h want %h", name, o, e);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1; start = 1; tick = 1; start_t = 1; tick_t = 1;
    player_en = '1; pos = '1; colours = '1;
    repeat (3) step();
    total++;
    if ({x, y, colour, plot, running, clearing, timer_x, done} !== '0) begin
      bad++;
      $display("FAIL reset_default: got %h want 0",
               {x, y, colour, plot, running, clearing, timer_x, done});
    end
    total++;
    if ({x_t, y_t, colour_t, plot_t, running_t, clearing_t, timer_x_t, done_t} !== '0) begin
      bad++;
      $display("FAIL reset_small: got %h want 0",
               {x_t, y_t, colour_t, plot_t, running_t, clearing_t, timer_x_t, done_t});
    end
    reset = 0; start = 0; tick = 0; start_t = 0; tick_t = 0;
    player_en = '0;
    repeat (3) begin
      step();
      total++;
      if ({plot, clearing, running} !== 3'b000) begin
        bad++;
        $display("FAIL idle_after_reset: got %b want 000", {plot, clearing, running});
      end
    end
  endtask

  task automatic test_clear();
    int guard;
    player_en = '0;
    start = 1; step(); start = 0;
    total++;
    if ({clearing, running, plot} !== 3'b100) begin
      bad++;
      $display("FAIL clear_entry: got %b want 100", {clearing, running, plot});
    end
    for (int yy = 0; yy < 120; yy++)
      for (int xx = 0; xx < 160; xx++) push(1'b1, xx, yy, 3'b000);
    guard = 0;
    while (exp_q.size() > 0 && guard < 19300) begin
      step();
      guard++;
      if (plot) begin
        e = exp_q.pop_front();
        o = {plot, x, y, colour};
        total++;
        if (o !== e) begin
          bad++;
          $display("FAIL clear_pixel: got %h want %h", o, e);
        end
      end
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL clear_timeout: got %0d pixels left want 0", exp_q.size());
      exp_q.delete();
    end
    step();
    total++;
    if ({plot, running, clearing, timer_x} !== {3'b010, 8'd0}) begin
      bad++;
      $display("FAIL clear_to_draw: got %h want %h", {plot, running, clearing, timer_x},
               {3'b010, 8'd0});
    end
  endtask

  task automatic test_round_robin();
    int guard;
    repeat (5) begin
      tick = 1; step(); tick = 0; step();
    end
    total++;
    if (timer_x !== 8'd5) begin
      bad++;
      $display("FAIL timer_count: got %0d want 5", timer_x);
    end
    guard = 0;
    while (!(plot && y == 7'd119) && guard < 10) begin
      step();
      guard++;
    end
    total++;
    if (!(plot && y == 7'd119)) begin
      bad++;
      $display("FAIL rr_sync: got plot=%b y=%0d want timer pixel", plot, y);
    end
    set_player(0, 10, 20, 3'b001);
    set_player(1, 30, 40, 3'b010);
    set_player(2, 50, 60, 3'b100);
    set_player(3, 70, 80, 3'b110);
    player_en = 4'b1011;
    repeat (3) begin
      push(1, 10, 20, 3'b001);
      push(1, 30, 40, 3'b010);
      push(0, 30, 40, 3'b010);
      push(1, 70, 80, 3'b110);
      push(1, 5, 119, 3'b111);
    end
    drain_every_cycle("round_robin");
  endtask

  task automatic test_out_of_range();
    set_player(0, 200, 20, 3'b001);
    repeat (2) begin
      push(0, 5, 119, 3'b111);
      push(1, 30, 40, 3'b010);
      push(0, 30, 40, 3'b010);
      push(1, 70, 80, 3'b110);
      push(1, 5, 119, 3'b111);
    end
    drain_every_cycle("out_of_range");
    set_player(0, 10, 20, 3'b001);
  endtask

  task automatic test_restart();
    repeat (35) begin
      tick = 1; step(); tick = 0; step();
    end
    total++;
    if ({running, timer_x} !== {1'b1, 8'd40}) begin
      bad++;
      $display("FAIL restart_pre: got %h want %h", {running, timer_x}, {1'b1, 8'd40});
    end
    start = 1; step(); start = 0;
    total++;
    if ({running, clearing, done, plot} !== 4'b0100) begin
      bad++;
      $display("FAIL restart_entry: got %b want 0100", {running, clearing, done, plot});
    end
    push(1, 0, 0, 3'b000);
    push(1, 1, 0, 3'b000);
    push(1, 2, 0, 3'b000);
    while (exp_q.size() > 0) begin
      step();
      e = exp_q.pop_front();
      o = {plot, x, y, colour};
      total++;
      if (o !== e || done !== 1'b0) begin
        bad++;
        $display("FAIL restart_sweep: got %h done=%b want %h done=0", o, done, e);
      end
    end
  endtask

  // Small-instance sweep (8x4) through the scoreboard, then check DRAW entry.
  task automatic small_sweep(input string name);
    int guard;
    start_t = 1; step(); start_t = 0;
    for (int yy = 0; yy < 4; yy++)
      for (int xx = 0; xx < 8; xx++) push(1'b1, xx, yy, 3'b000);
    guard = 0;
    while (exp_q.size() > 0 && guard < 60) begin
      step();
      guard++;
      if (plot_t) begin
        e = exp_q.pop_front();
        o = {plot_t, x_t, y_t, colour_t};
        total++;
        if (o !== e) begin
          bad++;
          $display("FAIL %s_pixel: got %h want %h", name, o, e);
        end
      end
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL %s_timeout: got %0d left want 0", name, exp_q.size());
      exp_q.delete();
    end
    step();
    total++;
    if ({plot_t, running_t, clearing_t, timer_x_t} !== {3'b010, 8'd0}) begin
      bad++;
      $display("FAIL %s_draw: got %h want %h", name, {plot_t, running_t, clearing_t, timer_x_t},
               {3'b010, 8'd0});
    end
  endtask

  task automatic test_timer_expiry();
    small_sweep("small_sweep");
    for (int i = 1; i <= 3; i++) begin
      tick_t = 1; step(); tick_t = 0;
      total++;
      if ({timer_x_t, running_t, done_t} !== {8'(i), 2'b10}) begin
        bad++;
        $display("FAIL expiry_count: got %h want %h", {timer_x_t, running_t, done_t},
                 {8'(i), 2'b10});
      end
    end
    tick_t = 1; step(); tick_t = 0;
    total++;
    if ({done_t, running_t, plot_t, timer_x_t} !== {3'b100, 8'd3}) begin
      bad++;
      $display("FAIL expiry_done: got %h want %h", {done_t, running_t, plot_t, timer_x_t},
               {3'b100, 8'd3});
    end
    step();
    total++;
    if ({done_t, plot_t} !== 2'b00) begin
      bad++;
      $display("FAIL expiry_pulse: got %b want 00", {done_t, plot_t});
    end
    tick_t = 1; step(); tick_t = 0;
    total++;
    if ({timer_x_t, done_t, plot_t} !== {8'd3, 2'b00}) begin
      bad++;
      $display("FAIL expiry_saturate: got %h want %h", {timer_x_t, done_t, plot_t},
               {8'd3, 2'b00});
    end
  endtask

  task automatic test_start_tick();
    small_sweep("restart_sweep");
    repeat (2) begin
      tick_t = 1; step(); tick_t = 0;
    end
    start_t = 1; tick_t = 1; step(); start_t = 0; tick_t = 0;
    total++;
    if ({clearing_t, running_t, done_t, timer_x_t} !== {3'b100, 8'd2}) begin
      bad++;
      $display("FAIL start_tick: got %h want %h", {clearing_t, running_t, done_t, timer_x_t},
               {3'b100, 8'd2});
    end
  endtask

  initial begin
    test_reset();
    test_clear();
    test_round_robin();
    test_out_of_range();
    test_restart();
    test_timer_expiry();
    test_start_tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/plot_sequencer.md
Name: plot_sequencer

Overview:
- Parametrised successor to the fixed four-player round-robin pixel drawer.
- Sweeps N player head pixels plus the timer-bar pixel to the vga_adapter plot port, one pixel per CLOCK_50 cycle.
- Adds a full-screen clear sweep on round start, per-player enable mask and configurable colours.
- Owns the round timer; drives the game's `running` flag and a one-cycle `done` pulse.

Parameters:
- NUM_PLAYERS, default 4: number of player slots, 1..8.
- X_W, default 8: x coordinate width.
- Y_W, default 7: y coordinate width.
- SCREEN_W, default 160: visible columns.
- SCREEN_H, default 120: visible rows.
- TIMER_Y, default 119: row of the timer bar.
- TIMER_LEN, default 158: last timer_x value; the round ends on the tick after this value is reached.
- BG_COLOUR, default 3'b000: colour used by the clear sweep.
- TIMER_COLOUR, default 3'b111: colour of the timer pixel.

Ports:
- CLOCK_50  in  1  system clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high.
- start  in  1  one-cycle pulse; begins a new round (clear sweep, then run).
- tick  in  1  one-cycle pulse; advances the timer.
- player_en  in  NUM_PLAYERS  bit k enables player k.
- pos  in  NUM_PLAYERS*(X_W+Y_W)  player k position at [k*(X_W+Y_W) +: X_W+Y_W]; upper X_W bits are x, lower Y_W bits are y.
- colours  in  NUM_PLAYERS*3  player k colour at [k*3 +: 3].
- x  out  X_W  plot x.
- y  out  Y_W  plot y.
- colour  out  3  plot colour.
- plot  out  1  write-enable to vga_adapter.
- running  out  1  round in progress.
- clearing  out  1  clear sweep active.
- timer_x  out  X_W  current timer value.
- done  out  1  one-cycle pulse at round end.

Behaviour:
- Reset values: state IDLE, x=0, y=0, colour=0, plot=0, running=0, clearing=0, timer_x=0, done=0. Reset has priority over all other inputs.
- All outputs are registered. The pixel selected in state cycle n appears on x/y/colour/plot in cycle n+1.
- States: IDLE, CLEAR, DRAW.
- IDLE:
  - plot=0; x/y/colour hold.
  - start -> CLEAR with cx=0, cy=0, clearing=1.
- CLEAR:
  - Each cycle emits plot=1, (cx,cy), BG_COLOUR.
  - cx increments fastest; at cx=SCREEN_W-1 it wraps to 0 and cy increments.
  - Exactly SCREEN_W*SCREEN_H plot cycles; the last pixel is (SCREEN_W-1, SCREEN_H-1).
  - The cycle after the last pixel: state DRAW, slot=0, running=1, clearing=0, timer_x=0.
  - start during CLEAR restarts the sweep at (0,0).
  - tick during CLEAR is ignored.
- DRAW: slot counter runs 0..NUM_PLAYERS, wraps to 0; period NUM_PLAYERS+1 cycles.
  - Slot k < NUM_PLAYERS: x/y from player k's pos, colour from its colours entry.
    - plot=1 only if player_en[k]=1 and x<SCREEN_W and y<SCREEN_H.
    - Otherwise plot=0 and x/y/colour hold; the slot is still consumed, so cadence is fixed.
  - Slot NUM_PLAYERS: x=timer_x, y=TIMER_Y, colour=TIMER_COLOUR, plot=1.
  - tick in DRAW:
    - If timer_x<TIMER_LEN: timer_x+1.
    - If timer_x==TIMER_LEN: running=0, done=1 for one cycle, state IDLE, timer_x holds (saturates).
  - A tick coinciding with the timer slot: the slot uses the pre-increment timer_x.
  - start in DRAW aborts the round: running=0, CLEAR from (0,0); done is not pulsed.
- start and tick in the same cycle: start wins; tick is dropped.
- player_en, pos and colours are sampled at the slot's cycle. Changes mid-period affect only slots not yet visited.
- Width rules:
  - cx is X_W bits; cy is Y_W bits.
  - Slot counter is ceil(log2(NUM_PLAYERS+1)) bits.
  - SCREEN_W must be <= 2^X_W and SCREEN_H <= 2^Y_W; violations are an elaboration error.

Test Plan:
- Reset: hold reset 3 cycles with start=1 and tick=1 -> all outputs 0, state IDLE, no plot.
- Clear sweep: start pulse -> exactly 19200 plot cycles with colour 000; first pixel (0,0), 161st pixel (0,1), last (159,119); running=1 the cycle after, timer_x=0.
- Round robin: pos p0=(10,20), p1=(30,40), p2=(50,60), p3=(70,80), colours 001/010/100/110, player_en=4'b1011, timer_x=5 -> repeating 5-cycle pattern: (10,20,001) plot; (30,40,010) plot; plot=0 with hold; (70,80,110) plot; (5,119,111) plot.
- Out of range: p0 x=200 with player_en[0]=1 -> slot 0 plot=0; other slots unaffected.
- Timer expiry: TIMER_LEN=3, four ticks in DRAW -> timer_x 1,2,3 then done=1 for exactly one cycle, running=0, plot=0; a further tick leaves timer_x=3.
- Restart: start while running with timer_x=40 -> running=0 next cycle, clearing=1, sweep from (0,0), no done pulse; start+tick in the same cycle during DRAW -> CLEAR entered, timer_x not incremented.
